// File: rtl/pwm_core_pkg.sv
// Shared constants for the PWM counter/compare engine: FSM state encoding,
// default widths and the zero-count value.
package pwm_core_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_DT_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [DEF_WIDTH-1:0] ZERO_COUNT = '0;

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary output stage: registers raw onto pwm_h/pwm_l and blanks both
// sides for dead_time cycles after every raw transition.
module pwm_deadtime
    import pwm_core_pkg::*;
#(
    parameter int DT_WIDTH = DEF_DT_WIDTH
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clear,
    input  logic                i_raw,
    input  logic [DT_WIDTH-1:0] i_dead_time,
    output logic                o_pwm_h,
    output logic                o_pwm_l
);

    logic                r_prev_raw;
    logic [DT_WIDTH-1:0] r_dt_cnt;
    logic                r_pwm_h;
    logic                r_pwm_l;

    logic                w_edge;
    logic [DT_WIDTH-1:0] w_dt_nxt;
    logic                w_gap;

    assign w_edge = (i_raw != r_prev_raw);

    // The gap is judged on the post-edge count so dead_time=N yields exactly N blank cycles.
    always_comb begin
        w_dt_nxt = r_dt_cnt;
        if (w_edge) begin
            w_dt_nxt = i_dead_time;
        end else if (r_dt_cnt != '0) begin
            w_dt_nxt = r_dt_cnt - 1'b1;
        end
    end

    assign w_gap = (w_dt_nxt != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_prev_raw <= 1'b0;
            r_dt_cnt   <= '0;
            r_pwm_h    <= 1'b0;
            r_pwm_l    <= 1'b0;
        end else begin
            r_prev_raw <= i_raw;
            r_dt_cnt   <= w_dt_nxt;
            r_pwm_h    <= i_raw & ~w_gap;
            r_pwm_l    <= ~i_raw & ~w_gap;
        end
    end

    assign o_pwm_h = r_pwm_h;
    assign o_pwm_l = r_pwm_l;

endmodule

// File: rtl/pwm_core.sv
// PWM counter/compare engine: IDLE/RUN/DRAIN sequencing, period counter,
// rollover pulse for the shadow-register stage and raw compare.
module pwm_core
    import pwm_core_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DT_WIDTH = DEF_DT_WIDTH
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic [WIDTH-1:0]    i_duty_reg,
    input  logic [WIDTH-1:0]    i_period_reg,
    input  logic [DT_WIDTH-1:0] i_dead_time,
    output logic                o_rollover,
    output logic [WIDTH-1:0]    o_count,
    output logic                o_pwm_h,
    output logic                o_pwm_l,
    output logic                o_busy,
    output state_t              o_state
);

    localparam logic [WIDTH-1:0] COUNT_ZERO = WIDTH'(ZERO_COUNT);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_busy;
    logic             w_at_end;
    logic             w_raw;
    logic             w_clear;

    assign w_busy   = (r_state != ST_IDLE);
    assign w_at_end = (r_count == i_period_reg);
    assign w_raw    = w_busy & (r_count < i_duty_reg);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_enable) w_state_nxt = ST_RUN;
            ST_RUN:   if (!i_enable) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (i_enable) begin
                    w_state_nxt = ST_RUN;
                end else if (w_at_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // A shrunken period can leave count above period_reg; plain increment then wraps through all-ones.
    always_comb begin
        w_count_nxt = r_count + 1'b1;
        if (!w_busy || (w_state_nxt == ST_IDLE) || w_at_end) begin
            w_count_nxt = COUNT_ZERO;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_count <= COUNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Outputs are held low in IDLE and forced low on the edge that returns to IDLE.
    assign w_clear = !w_busy || (w_state_nxt == ST_IDLE);

    pwm_deadtime #(
        .DT_WIDTH (DT_WIDTH)
    ) u_deadtime (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_clear),
        .i_raw       (w_raw),
        .i_dead_time (i_dead_time),
        .o_pwm_h     (o_pwm_h),
        .o_pwm_l     (o_pwm_l)
    );

    assign o_rollover = w_busy & w_at_end;
    assign o_count    = r_count;
    assign o_busy     = w_busy;
    assign o_state    = r_state;

endmodule

// File: tb/tb_pwm_core.sv
// Bench for pwm_core: driver pushes reference-model expectations per cycle,
// a monitor on the falling edge pops and compares them.
module tb_pwm_core;

    localparam int W   = 8;
    localparam int DTW = 4;
    localparam int EW  = W + 4;
    localparam int AGE_MAX = 1000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n      = 1'b0;
    logic           enable     = 1'b0;
    logic [W-1:0]   duty_reg   = '0;
    logic [W-1:0]   period_reg = '0;
    logic [DTW-1:0] dead_time  = '0;

    logic           rollover;
    logic [W-1:0]   count;
    logic           pwm_h;
    logic           pwm_l;
    logic           busy;
    logic [1:0]     state_dbg;

    pwm_core #(.WIDTH(W), .DT_WIDTH(DTW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_duty_reg   (duty_reg),
        .i_period_reg (period_reg),
        .i_dead_time  (dead_time),
        .o_rollover   (rollover),
        .o_count      (count),
        .o_pwm_h      (pwm_h),
        .o_pwm_l      (pwm_l),
        .o_busy       (busy),
        .o_state      (state_dbg)
    );

    // ---------------- stimulus settings ----------------
    logic           s_rst    = 1'b0;
    logic           s_en     = 1'b0;
    logic [W-1:0]   s_duty   = '0;
    logic [W-1:0]   s_period = '0;
    logic [DTW-1:0] s_dt     = '0;

    // ---------------- reference model ----------------
    // Behavioural view: "busy" plus a "draining" flag, and dead time expressed as
    // the age of the most recent raw transition versus the dead_time seen then.
    logic         m_busy  = 1'b0;
    logic         m_drain = 1'b0;
    logic [W-1:0] m_count = '0;
    logic         m_h     = 1'b0;
    logic         m_l     = 1'b0;
    logic         m_prev  = 1'b0;
    int           m_age   = AGE_MAX;
    int           m_gap   = 0;

    task automatic model_edge();
        logic raw, roll, was_busy, leave;
        raw      = m_busy && (m_count < duty_reg);
        roll     = m_busy && (m_count == period_reg);
        was_busy = m_busy;
        if (!rst_n) begin
            m_busy = 1'b0; m_drain = 1'b0; m_count = '0;
            m_h = 1'b0; m_l = 1'b0; m_prev = 1'b0; m_age = AGE_MAX;
            return;
        end
        leave = m_busy && m_drain && !enable && roll;
        if (!m_busy) begin
            m_busy = enable; m_drain = 1'b0; m_count = '0;
        end else if (leave) begin
            m_busy = 1'b0; m_drain = 1'b0; m_count = '0;
        end else begin
            m_drain = !enable;
            m_count = roll ? '0 : m_count + 1'b1;
        end
        if (!was_busy || !m_busy) begin
            m_h = 1'b0; m_l = 1'b0; m_prev = 1'b0; m_age = AGE_MAX;
        end else begin
            if (raw != m_prev) begin
                m_prev = raw; m_age = 0; m_gap = int'(dead_time);
            end else if (m_age < AGE_MAX) begin
                m_age++;
            end
            m_h = raw && (m_age >= m_gap);
            m_l = !raw && (m_age >= m_gap);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  timeouts = 0;
    int  cyc      = 0;
    bit  done     = 1'b0;

    // ---------------- driver tasks ----------------
    task automatic drive_cycle();
        logic roll;
        @(posedge clk);
        model_edge();
        #1;
        rst_n = s_rst; enable = s_en; duty_reg = s_duty;
        period_reg = s_period; dead_time = s_dt;
        cyc++;
        roll = m_busy && (m_count == period_reg);
        exp_q.push_back({m_count, roll, m_busy, m_h, m_l});
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle();
    endtask

    task automatic run_to_count(input logic [W-1:0] c);
        int k;
        k = 0;
        do begin
            drive_cycle();
            k++;
        end while (!(m_busy && m_count == c) && k < 600);
        if (!(m_busy && m_count == c)) timeouts++;
    endtask

    task automatic setup(input logic en, input int d, input int p, input int t);
        s_en = en; s_duty = W'(d); s_period = W'(p); s_dt = DTW'(t);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        s_rst = 1'b0;
        setup(1'b0, 0, 0, 0);
        run_cycles(3);
        s_rst = 1'b1;
        run_cycles(2);

        // basic waveform
        setup(1'b1, 3, 9, 0);
        run_cycles(32);
        // dead time, changed at a period boundary
        run_to_count(9);
        setup(1'b1, 5, 9, 2);
        run_cycles(35);
        // duty extremes and period 0
        run_to_count(9);
        setup(1'b1, 0, 9, 1);
        run_cycles(22);
        run_to_count(9);
        setup(1'b1, 12, 9, 1);
        run_cycles(22);
        run_to_count(9);
        setup(1'b1, 3, 0, 0);
        run_cycles(6);

        // graceful stop, then re-raise during drain
        setup(1'b1, 3, 9, 1);
        run_to_count(9);
        run_to_count(4);
        s_en = 1'b0;
        run_cycles(12);
        s_en = 1'b1;
        run_to_count(4);
        s_en = 1'b0;
        run_to_count(6);
        s_en = 1'b1;
        run_cycles(15);

        // reset mid-operation with enable still high
        run_to_count(5);
        s_rst = 1'b0;
        run_cycles(1);
        s_rst = 1'b1;
        run_cycles(14);

        // live update committed at rollover
        setup(1'b1, 3, 9, 0);
        run_to_count(2);
        run_to_count(9);
        s_duty = 8'd7;
        run_cycles(22);

        // period shrunk below count: wrap through all-ones
        setup(1'b1, 4, 20, 0);
        run_to_count(15);
        s_period = 8'd5;
        run_to_count(5);
        run_cycles(10);

        // randomized segments
        for (int s = 0; s < 40; s++) begin
            setup(($urandom_range(0, 3) != 0), $urandom_range(0, 18),
                  $urandom_range(0, 15), $urandom_range(0, 3));
            s_rst = ($urandom_range(0, 11) != 0);
            run_cycles(1);
            s_rst = 1'b1;
            run_cycles($urandom_range(3, 40));
        end

        s_en = 1'b0;
        run_cycles(300);
        repeat (2) @(posedge clk);
        done = 1'b1;
    end

    // ---------------- monitor + final report ----------------
    initial begin : monitor
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {count, rollover, busy, pwm_h, pwm_l};
                n_checks++;
                if (got === e) n_pass++;
                else $display("FAIL outputs t=%0t: got cnt=%0d roll=%b busy=%b h=%b l=%b, expected cnt=%0d roll=%b busy=%b h=%b l=%b",
                              $time, got[EW-1:4], got[3], got[2], got[1], got[0],
                              e[EW-1:4], e[3], e[2], e[1], e[0]);
                n_checks++;
                if (!(pwm_h === 1'b1 && pwm_l === 1'b1)) n_pass++;
                else $display("FAIL overlap t=%0t: pwm_h=%b pwm_l=%b, required not both 1", $time, pwm_h, pwm_l);
            end
        end
        n_checks++;
        if (timeouts == 0) n_pass++;
        else $display("FAIL stimulus_timeout: got %0d expired waits, required 0", timeouts);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL leftover_expect: got %0d unchecked entries, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit after %0d cycles", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pwm_core.md
Name: pwm_core

Overview:
- Counter/compare engine on the consuming side of the duty/period shadow-register interface.
- Takes the live duty_reg/period_reg values and generates the period counter and the raw PWM compare.
- Drives complementary high/low-side outputs with programmable dead time.
- Emits the one-cycle rollover pulse that tells the register stage when it may commit new values.

Parameters:
- WIDTH, 8, width of count, duty and period.
- DT_WIDTH, 4, width of the dead-time count.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  run request; level-sensitive.
- duty_reg  in  WIDTH  active duty (high cycles per period).
- period_reg  in  WIDTH  active period; one PWM period is period_reg+1 cycles.
- dead_time  in  DT_WIDTH  dead-time cycles inserted at each raw edge.
- rollover  out  1  one-cycle pulse in the last cycle of a period.
- count  out  WIDTH  current counter value.
- pwm_h  out  1  high-side drive.
- pwm_l  out  1  low-side drive.
- busy  out  1  high in RUN or DRAIN.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, count=0, rollover=0, pwm_h=0, pwm_l=0, busy=0, dead-time counter=0. Reset mid-period aborts the period immediately; no drain.
- States:
  - IDLE -> RUN when enable=1. The first RUN cycle has count=0.
  - RUN -> DRAIN when enable=0.
  - DRAIN -> RUN when enable returns to 1 before the period ends; the counter is not disturbed.
  - DRAIN -> IDLE on the edge after the rollover cycle; count returns to 0.
- In IDLE: count is held at 0, rollover=0, pwm_h=0, pwm_l=0, dead-time counter cleared.
- Counter: in RUN/DRAIN it increments each cycle. When count==period_reg it wraps to 0 on the next edge. WIDTH-bit unsigned compare.
- rollover=1 combinationally while busy and count==period_reg. Values the register stage commits on that edge apply from count=0 of the next period.
- period_reg changed mid-period (only possible outside the register stage's control): if count > period_reg, the counter keeps incrementing and wraps through 2^WIDTH-1 -> 0. No rollover is emitted until count==period_reg.
- period_reg=0: every busy cycle is a rollover; count stays 0.
- Raw compare: raw = (count < duty_reg), evaluated only when busy, else 0.
  - duty_reg=0 gives a constant 0.
  - duty_reg=period_reg gives high for period_reg cycles and low for 1.
  - duty_reg > period_reg gives a constant 1.
- Outputs are registered, with one cycle of latency from raw to pwm_h/pwm_l.
- Dead time:
  - When raw differs from its previous registered value: force pwm_h=0 and pwm_l=0, and load the dead-time counter with dead_time.
  - While the counter is nonzero: both outputs stay 0 and the counter decrements.
  - At zero: pwm_h=raw, pwm_l=~raw.
  - A raw edge during dead time reloads the counter.
  - dead_time=0: no gap; pwm_h=raw and pwm_l=~raw, delayed 1 cycle.
- Invariant: pwm_h and pwm_l are never 1 in the same cycle, in any state, including during and after reset.
- Leaving RUN/DRAIN for IDLE forces both outputs to 0 on the same edge.
- dead_time is sampled only at the reload edge.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, RUN, DRAIN);
  - default WIDTH/DT_WIDTH constants;
  - a zero-count constant.
- One sub-module, pwm_deadtime: takes raw and dead_time, returns pwm_h/pwm_l, owns the dead-time counter and previous-raw register, same clk/rst_n.
- The FSM and period counter stay in pwm_core.

Test Plan:
- Basic PWM: period=9, duty=3, dead_time=0, enable=1 -> rollover every 10 cycles at count=9; pwm_h high 3 of every 10 cycles; pwm_l its complement one cycle delayed.
- Dead time: period=9, duty=5, dead_time=2 -> two cycles with both outputs low after each raw edge; pwm_h high 3 cycles per period; pwm_h & pwm_l never both 1.
- Duty extremes: duty=0 -> pwm_h stays 0 and pwm_l=1 after the first cycle; duty=12 with period=9 -> pwm_h constant 1; period=0 -> rollover=1 every busy cycle.
- Graceful stop:
  - Drop enable at count=4 with period=9: count continues to 9, rollover pulses, IDLE next, busy=0, outputs 0.
  - Re-raise enable at count=6 while in DRAIN: stays RUN with no counter glitch.
- Reset mid-operation: rst_n=0 at count=5 with pwm_h=1 -> after that edge count=0, pwm_h=pwm_l=0, rollover=0, state IDLE; with enable still 1, the first post-reset RUN cycle has count=0.
- Live update with the register stage: change duty 3->7 at count=2 of a period=9 run -> new duty visible only from count=0 after the next rollover.
